// File: rtl/mdu_iter_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_iter_ctrl
//
// Iterative RV32M multiply/divide sequencer for the execute stage. Accepts one
// M-type operation, runs a radix-2 shift-add multiply or a restoring divide
// over 32 cycles, applies sign correction and the RISC-V divide corner cases,
// and returns the result. The EX stage is held through stall_o while busy.
//
// Ports:
//   clk          core clock, rising edge
//   rst_n        synchronous active-low reset
//   start_i      request a new operation (sampled only in IDLE)
//   operator_i   RV32M funct3 (MUL..REMU)
//   operand_a_i  rs1 value
//   operand_b_i  rs2 value
//   kill_i       flush, aborts any in-flight operation (priority over start_i)
//   stall_o      EX stage must hold its instruction
//   valid_o      one-cycle pulse, result_o valid
//   result_o     result, holds its last value until the next completion
//
// Build option:
//   MDU_FAST_PATH_EN  when defined, divide-by-zero and multiply-by-zero skip
//                     COMPUTE and go straight to FIXUP (same results, shorter
//                     latency).
// -----------------------------------------------------------------------------
module mdu_iter_ctrl #(
    parameter int WORD_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [2:0]            operator_i,
    input  logic [WORD_WIDTH-1:0] operand_a_i,
    input  logic [WORD_WIDTH-1:0] operand_b_i,
    input  logic                  kill_i,
    output logic                  stall_o,
    output logic                  valid_o,
    output logic [WORD_WIDTH-1:0] result_o
);

    localparam int W  = WORD_WIDTH;
    localparam int DW = 2 * WORD_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        FIXUP,
        DONE
    } state_e;

    // Control state
    state_e                 state_q,  state_d;
    logic [CNT_WIDTH-1:0]   cnt_q,    cnt_d;
    logic [W-1:0]           result_q, result_d;

    // Datapath state. acc holds {upper partial product, multiplier} for a
    // multiply and {remainder, dividend/quotient} for a divide.
    logic [2:0]             op_q,     op_d;
    logic [DW-1:0]          acc_q,    acc_d;
    logic [W-1:0]           mcand_q,  mcand_d;   // |b|: multiplicand or divisor
    logic [W-1:0]           opa_q,    opa_d;     // raw rs1, for divide-by-zero remainder
    logic                   sign_a_q, sign_a_d;
    logic                   sign_b_q, sign_b_d;

    // Operand conditioning at acceptance
    logic         a_signed, b_signed, neg_a, neg_b, fast_path;
    logic [W-1:0] mag_a, mag_b;

    // Iteration step results
    logic [W:0]   mul_sum;
    logic [DW-1:0] mul_next;
    logic [W:0]   rem_shift;
    logic [W-1:0] quo_shift;
    logic [W-1:0] div_diff;
    logic         div_ge;
    logic [DW-1:0] div_next;

    // Fixup results
    logic [DW-1:0] product;
    logic [W-1:0]  mul_res, quo_res, rem_res, div_res;

    always_comb begin
        // funct3[2] selects divide; within each group the encodings decide
        // which operands are signed (MULHSU: a only, *U: neither).
        a_signed = operator_i[2] ? ~operator_i[0] : (operator_i[1:0] != 2'b11);
        b_signed = operator_i[2] ? ~operator_i[0] : ~operator_i[1];
        neg_a    = a_signed & operand_a_i[W-1];
        neg_b    = b_signed & operand_b_i[W-1];
        mag_a    = neg_a ? -operand_a_i : operand_a_i;
        mag_b    = neg_b ? -operand_b_i : operand_b_i;
`ifdef MDU_FAST_PATH_EN
        fast_path = operator_i[2] ? (operand_b_i == '0)
                                  : ((operand_a_i == '0) || (operand_b_i == '0));
`else
        fast_path = 1'b0;
`endif

        // Multiply step: conditional add into the upper half, carry kept so
        // the right shift brings it back in.
        mul_sum  = {1'b0, acc_q[DW-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_next = {mul_sum, acc_q[W-1:1]};

        // Divide step: shift {rem, quo} left, trial-subtract the divisor. The
        // shifted remainder can need W+1 bits, but after a successful
        // subtract it is below the divisor, so W bits of difference suffice.
        rem_shift = acc_q[DW-1:W-1];
        quo_shift = {acc_q[W-2:0], 1'b0};
        div_ge    = rem_shift >= {1'b0, mcand_q};
        div_diff  = rem_shift[W-1:0] - mcand_q;
        div_next  = div_ge ? {div_diff, quo_shift | W'(1)}
                           : {rem_shift[W-1:0], quo_shift};

        // Sign correction. Signed overflow (INT_MIN / -1) yields INT_MIN and
        // remainder 0 through the magnitude path with no special case.
        product = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        mul_res = (op_q[1:0] == 2'b00) ? product[W-1:0] : product[DW-1:W];
        if (mcand_q == '0) begin
            quo_res = '1;
            rem_res = opa_q;
        end else begin
            quo_res = (sign_a_q ^ sign_b_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
            rem_res = sign_a_q ? -acc_q[DW-1:W] : acc_q[DW-1:W];
        end
        div_res = op_q[1] ? rem_res : quo_res;
    end

    // NOTE: every *_d gets its hold value first so no path through this block
    // leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        op_d     = op_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        opa_d    = opa_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = fast_path ? FIXUP : COMPUTE;
                    cnt_d    = '0;
                    op_d     = operator_i;
                    // A zero accumulator makes FIXUP yield 0 for a skipped multiply.
                    acc_d    = fast_path ? '0 : {{W{1'b0}}, mag_a};
                    mcand_d  = mag_b;
                    opa_d    = operand_a_i;
                    sign_a_d = neg_a;
                    sign_b_d = neg_b;
                end
            end
            COMPUTE: begin
                acc_d = op_q[2] ? div_next : mul_next;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIXUP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            FIXUP: begin
                result_d = op_q[2] ? div_res : mul_res;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over everything: back to IDLE with the old result kept.
        if (kill_i) begin
            state_d  = IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    // NOTE: state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // NOTE: the datapath registers have no reset; they are always loaded at
    // acceptance before anything reads them.
    always_ff @(posedge clk) begin
        op_q     <= op_d;
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        opa_q    <= opa_d;
        sign_a_q <= sign_a_d;
        sign_b_q <= sign_b_d;
    end

    assign stall_o  = ((state_q == IDLE) & start_i & ~kill_i)
                    | (state_q == COMPUTE) | (state_q == FIXUP);
    assign valid_o  = (state_q == DONE);
    assign result_o = result_q;

endmodule

// File: doc/mdu_iter_ctrl.md
# mdu_iter_ctrl

Iterative multiply/divide sequencer for the RV32M extension, instantiated in the execute stage alongside the ALU. It accepts one M-type operation from the EX stage, runs a radix-2 shift-add multiply or restoring divide over 32 cycles, applies sign correction and RISC-V corner-case rules, and returns the result. While it works, it holds the pipeline through a stall handshake.

## Interface
- WORD_WIDTH, 32, operand/result width; only 32 is supported.
- CNT_WIDTH, 5, iteration counter width; equals log2(WORD_WIDTH).

- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset; one clock, reset is synchronous and active-low.
- start_i  input  1  request a new operation; sampled only in IDLE.
- operator_i  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a_i  input  WORD_WIDTH  rs1 value.
- operand_b_i  input  WORD_WIDTH  rs2 value.
- kill_i  input  1  flush; aborts any in-flight operation.
- stall_o  output  1  EX stage must hold its instruction.
- valid_o  output  1  result_o valid; one-cycle pulse.
- result_o  output  WORD_WIDTH  operation result; holds its last value until the next DONE.

## Operation
- FSM states: IDLE, COMPUTE, FIXUP, DONE.
- IDLE:
  - start_i=1 and kill_i=0: latch the operator. Latch |a| and |b| as unsigned magnitudes; signedness follows the operator (MULHSU treats b as unsigned; *U ops treat both as unsigned).
  - Latch sign flags. Clear the counter and go to COMPUTE.
- COMPUTE, multiply: 64-bit accumulator. Each cycle, if multiplier LSB=1, add the multiplicand to the upper half; then shift right by 1.
- COMPUTE, divide: 33-bit remainder/quotient shift register. Each cycle, shift left, trial-subtract the divisor, and set the quotient bit if the result is non-negative.
- COMPUTE exits to FIXUP when the counter reaches 31, i.e. after exactly 32 cycles.
- FIXUP, multiply:
  - Negate the 64-bit product if the result sign is 1 (sign_a^sign_b).
  - Select the low word for MUL, the high word for the others.
- FIXUP, divide:
  - Negate the quotient if sign_a^sign_b.
  - Negate the remainder if sign_a.
  - Divisor==0 overrides: quotient=0xFFFFFFFF and remainder=operand_a unmodified, for both signed and unsigned ops.
  - Signed overflow (0x80000000 / -1) yields quotient=0x80000000 and remainder=0; this falls out of the magnitude arithmetic and needs no special case.
- FIXUP registers result_o, then goes to DONE.
- DONE: valid_o=1 for one cycle, then IDLE. start_i is ignored in DONE.
- kill_i=1 in any state: next state IDLE, counter cleared, no valid_o pulse, result_o unchanged. kill_i has priority over start_i.
- start_i while not in IDLE is ignored.
- Operands are sampled only at acceptance; later changes on operand_a_i/operand_b_i have no effect.

## Timing
- Reset values: state IDLE, valid_o=0, result_o=0, counter=0; stall_o=0 while start_i=0.
- stall_o = (IDLE & start_i & ~kill_i) | COMPUTE | FIXUP. It is combinational in IDLE so the accepting cycle stalls, and it is 0 in DONE so the EX stage advances with the result.
- Latency, start accepted at edge T:
  - COMPUTE occupies T+1..T+32.
  - FIXUP at T+33.
  - valid_o=1 during T+34.
- The next start_i can be accepted at T+35 (IDLE). Issue interval is 35 cycles.
- Reset asserted mid-operation: IDLE on the next edge, no valid_o pulse.

## Configuration
- MDU_FAST_PATH_EN defined:
  - In IDLE, a divide with operand_b_i==0, or a multiply with either operand==0, goes straight to FIXUP. FIXUP produces the architecturally correct result.
  - valid_o then rises at T+2, and stall_o is high only for the accept cycle and FIXUP.
- MDU_FAST_PATH_EN undefined: every operation takes the full 32-cycle COMPUTE; valid_o at T+34.
- Results are identical in both builds; only latency differs.

## Test plan
- MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, valid_o at T+34, stall_o high T..T+33.
- MULH a=b=0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIVU a=5, b=0 -> 0xFFFFFFFF; REM a=0xFFFFFFF9, b=0 -> 0xFFFFFFF9. valid_o at T+34 without the macro, T+2 with MDU_FAST_PATH_EN.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0, no trap.
- Start DIV, assert kill_i at T+10 -> IDLE at T+11, no valid_o, result_o unchanged, stall_o=0 at T+11. New MUL 3*4 started at T+12 -> 12 at T+46. Then repeat with rst_n=0 at T+10: same abort behaviour.
